// File: rtl/prog_loader_if.sv
// Program-loader bus: word source handshake plus program-memory write port.
// The slave modport is the loader's view; master is the environment's view.
interface prog_loader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic              src_valid;
   logic [DATA_W-1:0] src_data;
   logic              src_ready;
   logic              prog_write;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;

   modport slave (
      input  src_valid, src_data,
      output src_ready, prog_write, prog_addr, prog_data
   );

   modport master (
      output src_valid, src_data,
      input  src_ready, prog_write, prog_addr, prog_data
   );
endinterface

// File: rtl/prog_loader.sv
// Program loader: clears the processor, optionally zero-fills program memory,
// streams prog_len words from a valid/ready source into memory, then lets the
// processor run until stopped. Every output except src_ready is registered;
// the comb process computes next-cycle values of all outputs from the
// next state so they line up with the state they describe.
module prog_loader #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 8,
   parameter int CLR_CYCLES = 1,
   parameter bit ZERO_FILL  = 1'b1
) (
   input  logic            clk_in,
   input  logic            clr,
   input  logic            start,
   input  logic            stop,
   input  logic [ADDR_W:0] prog_len,
   prog_loader_if.slave    bus,
   output logic            cpu_clr,
   output logic            cpu_run,
   output logic            done,
   output logic            error
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CPU_CLR = 3'd1,
      ZERO    = 3'd2,
      LOAD    = 3'd3,
      DRAIN   = 3'd4,
      RUN     = 3'd5
   } state_t;

   // DEPTH needs ADDR_W+1 bits so a full-memory program length is representable
   localparam logic [ADDR_W:0] DEPTH_L  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [3:0]      CLR_LAST = 4'(CLR_CYCLES - 1);

   state_t            state_q, state_nxt;
   logic [3:0]        clr_cnt_q, clr_cnt_nxt;
   logic [ADDR_W:0]   wcnt_q, wcnt_nxt;
   logic [ADDR_W:0]   len_q, len_nxt;
   logic              wr_q, wr_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] data_q, data_nxt;
   logic              cc_q, cc_nxt;
   logic              run_q, run_nxt;
   logic              done_q, done_nxt;
   logic              err_q, err_nxt;

   assign bus.src_ready  = (state_q == LOAD);
   assign bus.prog_write = wr_q;
   assign bus.prog_addr  = addr_q;
   assign bus.prog_data  = data_q;
   assign cpu_clr        = cc_q;
   assign cpu_run        = run_q;
   assign done           = done_q;
   assign error          = err_q;

   // Next-state and next-output logic
   always_comb begin
      state_nxt   = state_q;
      clr_cnt_nxt = clr_cnt_q;
      wcnt_nxt    = wcnt_q;
      len_nxt     = len_q;
      wr_nxt      = 1'b0;
      addr_nxt    = addr_q;
      data_nxt    = data_q;
      err_nxt     = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_nxt = prog_len;
               if (prog_len > DEPTH_L) begin
                  err_nxt = 1'b1;
               end else begin
                  err_nxt     = 1'b0;
                  state_nxt   = CPU_CLR;
                  clr_cnt_nxt = '0;
                  wcnt_nxt    = '0;
               end
            end
         end
         CPU_CLR: begin
            if (clr_cnt_q == CLR_LAST) begin
               if (ZERO_FILL) begin
                  // first zero write goes out in the first ZERO cycle
                  state_nxt = ZERO;
                  wr_nxt    = 1'b1;
                  addr_nxt  = '0;
                  data_nxt  = '0;
               end else if (len_q != '0) begin
                  state_nxt = LOAD;
               end else begin
                  state_nxt = RUN;
               end
            end else begin
               clr_cnt_nxt = clr_cnt_q + 4'd1;
            end
         end
         ZERO: begin
            // addr_q is the address being written this cycle
            if (addr_q == '1) begin
               state_nxt = (len_q != '0) ? LOAD : RUN;
            end else begin
               wr_nxt   = 1'b1;
               addr_nxt = addr_q + 1'b1;
               data_nxt = '0;
            end
         end
         LOAD: begin
            if (bus.src_valid) begin
               wr_nxt   = 1'b1;
               addr_nxt = wcnt_q[ADDR_W-1:0];
               data_nxt = bus.src_data;
               wcnt_nxt = wcnt_q + LEN_ONE;
               if (wcnt_q == len_q - LEN_ONE) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = RUN;
         end
         RUN: begin
            // stop has priority over a restart request
            if (stop) begin
               state_nxt = IDLE;
            end else if (start) begin
               state_nxt   = CPU_CLR;
               clr_cnt_nxt = '0;
               wcnt_nxt    = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      cc_nxt   = (state_nxt == CPU_CLR);
      run_nxt  = (state_nxt == RUN);
      done_nxt = (state_nxt == RUN) && (state_q != RUN);
   end

   // State and registered outputs; clr discards any in-flight word
   always_ff @(posedge clk_in) begin
      if (clr) begin
         state_q   <= IDLE;
         clr_cnt_q <= '0;
         wcnt_q    <= '0;
         len_q     <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         cc_q      <= 1'b0;
         run_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         clr_cnt_q <= clr_cnt_nxt;
         wcnt_q    <= wcnt_nxt;
         len_q     <= len_nxt;
         wr_q      <= wr_nxt;
         addr_q    <= addr_nxt;
         data_q    <= data_nxt;
         cc_q      <= cc_nxt;
         run_q     <= run_nxt;
         done_q    <= done_nxt;
         err_q     <= err_nxt;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: cycle-by-cycle vector table on a no-zero-fill
// instance, plus full-load sequences (zero-fill and full-depth).
module tb_prog_loader;
   localparam int DW = 32;
   localparam int AW = 8;

   logic          clk_in = 1'b0;
   logic          clr = 1'b0, start = 1'b0, stop = 1'b0, src_valid = 1'b0;
   logic [AW:0]   prog_len = '0;
   logic [DW-1:0] src_data = '0;
   logic          cc0, run0, dn0, er0, cc1, run1, dn1, er1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_in = ~clk_in;

   prog_loader_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
   prog_loader_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

   assign if0.src_valid = src_valid;
   assign if0.src_data  = src_data;
   assign if1.src_valid = src_valid;
   assign if1.src_data  = src_data;

   prog_loader #(.DATA_W(DW), .ADDR_W(AW), .CLR_CYCLES(2), .ZERO_FILL(1'b0)) dut0 (
      .clk_in(clk_in), .clr(clr), .start(start), .stop(stop), .prog_len(prog_len),
      .bus(if0), .cpu_clr(cc0), .cpu_run(run0), .done(dn0), .error(er0));

   prog_loader #(.DATA_W(DW), .ADDR_W(AW), .CLR_CYCLES(2), .ZERO_FILL(1'b1)) dut1 (
      .clk_in(clk_in), .clr(clr), .start(start), .stop(stop), .prog_len(prog_len),
      .bus(if1), .cpu_clr(cc1), .cpu_run(run1), .done(dn1), .error(er1));

   // selected-DUT view for the sequence task
   bit            sel = 1'b0;
   logic          s_rdy, s_wr, s_cc, s_run, s_done;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_data;
   assign s_rdy  = sel ? if1.src_ready  : if0.src_ready;
   assign s_wr   = sel ? if1.prog_write : if0.prog_write;
   assign s_addr = sel ? if1.prog_addr  : if0.prog_addr;
   assign s_data = sel ? if1.prog_data  : if0.prog_data;
   assign s_cc   = sel ? cc1  : cc0;
   assign s_run  = sel ? run1 : run0;
   assign s_done = sel ? dn1  : dn0;

   typedef struct packed {
      logic          rdy, wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          cc, run, dn, err;
   } out_t;

   typedef struct {
      logic          clr, start, stop;
      logic [AW:0]   len;
      logic          vld;
      logic [DW-1:0] d;
      out_t          e;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic c, s, p, input logic [AW:0] l, input logic v,
                      input logic [DW-1:0] d, input logic r, w, input logic [AW-1:0] a,
                      input logic [DW-1:0] dd, input logic ec, er, edn, eer);
      vec_t t;
      t.clr = c; t.start = s; t.stop = p; t.len = l; t.vld = v; t.d = d;
      t.e = '{r, w, a, dd, ec, er, edn, eer};
      tbl.push_back(t);
   endtask

   // Drive start with prog_len, then stream words (valid held high) until done.
   // Expect 2 cpu_clr cycles, nzero zero writes, then len data writes at 0..len-1.
   task automatic run_load(input bit s, input int len, input logic [DW-1:0] base, input int nzero);
      int  k = 0, n_cc = 0, nw = 0, bad = 0;
      bit  got = 1'b0, run_ok = 1'b0, acc;
      sel = s;
      @(negedge clk_in); clr = 1'b1; start = 1'b0; stop = 1'b0; src_valid = 1'b0;
      @(negedge clk_in); clr = 1'b0; start = 1'b1; prog_len = 9'(len); src_valid = 1'b1;
      for (int c = 0; c < 800 && !got; c++) begin
         src_data = base + 32'(k);
         acc = s_rdy;
         @(posedge clk_in); #1;
         start = 1'b0;
         if (acc) k++;
         if (s_cc) n_cc++;
         if (s_wr) begin
            if (nw < nzero) begin
               if (s_addr != 8'(nw) || s_data != '0) bad++;
            end else if (s_addr != 8'(nw - nzero) || s_data != base + 32'(nw - nzero)) begin
               bad++;
            end
            nw++;
         end
         if (s_done) begin got = 1'b1; run_ok = s_run; end
         @(negedge clk_in);
      end
      src_valid = 1'b0;
      check($sformatf("ld%0d_done_seen", len), 64'(got), 64'd1);
      check($sformatf("ld%0d_cc_cycles", len), 64'(n_cc), 64'd2);
      check($sformatf("ld%0d_write_count", len), 64'(nw), 64'(nzero + len));
      check($sformatf("ld%0d_bad_writes", len), 64'(bad), 64'd0);
      check($sformatf("ld%0d_run_at_done", len), 64'(run_ok), 64'd1);
      @(posedge clk_in); #1;
      check($sformatf("ld%0d_after_done", len), {61'd0, s_done, s_run, s_wr}, 64'b010);
      @(negedge clk_in); stop = 1'b1;
      @(posedge clk_in); #1;
      check($sformatf("ld%0d_stop_run", len), 64'(s_run), 64'd0);
      @(negedge clk_in); stop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      out_t act, exp;
      //   clr st sp len    v  data           rdy wr addr data        cc run dn err
      add(1, 0, 0, 9'd0,   0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 0, 0, 0); // 0 reset
      add(0, 1, 0, 9'd0,   0, 32'h0,          0, 0, 8'd0, 32'h0,        1, 0, 0, 0); // 1 start len 0
      add(0, 0, 0, 9'd0,   0, 32'h0,          0, 0, 8'd0, 32'h0,        1, 0, 0, 0);
      add(0, 0, 0, 9'd0,   0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 1, 1, 0); // 3 run+done
      add(0, 0, 0, 9'd0,   0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 1, 0, 0);
      add(0, 0, 1, 9'd0,   0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 0, 0, 0); // 5 stop
      add(0, 1, 0, 9'd4,   0, 32'h0,          0, 0, 8'd0, 32'h0,        1, 0, 0, 0); // 6 len 4
      add(0, 0, 0, 9'd4,   0, 32'h0,          0, 0, 8'd0, 32'h0,        1, 0, 0, 0);
      add(0, 0, 0, 9'd4,   0, 32'h0,          1, 0, 8'd0, 32'h0,        0, 0, 0, 0); // 8 LOAD
      add(0, 0, 0, 9'd4,   1, 32'h1000_0001,  1, 1, 8'd0, 32'h1000_0001, 0, 0, 0, 0);
      add(0, 0, 0, 9'd4,   0, 32'h0,          1, 0, 8'd0, 32'h0,        0, 0, 0, 0);
      add(0, 0, 0, 9'd4,   0, 32'h0,          1, 0, 8'd0, 32'h0,        0, 0, 0, 0);
      add(0, 0, 0, 9'd4,   1, 32'h1000_0002,  1, 1, 8'd1, 32'h1000_0002, 0, 0, 0, 0);
      add(0, 0, 0, 9'd4,   1, 32'h1000_0003,  1, 1, 8'd2, 32'h1000_0003, 0, 0, 0, 0);
      add(0, 0, 0, 9'd4,   0, 32'h0,          1, 0, 8'd0, 32'h0,        0, 0, 0, 0);
      add(0, 0, 0, 9'd4,   1, 32'h1000_0004,  0, 1, 8'd3, 32'h1000_0004, 0, 0, 0, 0); // 15 DRAIN
      add(0, 0, 0, 9'd4,   1, 32'hDEAD_BEEF,  0, 0, 8'd0, 32'h0,        0, 1, 1, 0); // 16 RUN
      add(0, 0, 0, 9'd4,   0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 1, 0, 0);
      add(0, 1, 0, 9'd4,   0, 32'h0,          0, 0, 8'd0, 32'h0,        1, 0, 0, 0); // 18 restart
      add(0, 0, 0, 9'd4,   0, 32'h0,          0, 0, 8'd0, 32'h0,        1, 0, 0, 0);
      add(0, 0, 0, 9'd4,   0, 32'h0,          1, 0, 8'd0, 32'h0,        0, 0, 0, 0);
      add(0, 0, 0, 9'd4,   1, 32'h2000_0000,  1, 1, 8'd0, 32'h2000_0000, 0, 0, 0, 0);
      add(0, 0, 0, 9'd4,   1, 32'h2000_0001,  1, 1, 8'd1, 32'h2000_0001, 0, 0, 0, 0);
      add(0, 0, 0, 9'd4,   1, 32'h2000_0002,  1, 1, 8'd2, 32'h2000_0002, 0, 0, 0, 0);
      add(1, 0, 0, 9'd4,   1, 32'h2000_0003,  0, 0, 8'd0, 32'h0,        0, 0, 0, 0); // 24 clr mid-LOAD
      add(0, 1, 0, 9'd2,   0, 32'h0,          0, 0, 8'd0, 32'h0,        1, 0, 0, 0);
      add(0, 0, 0, 9'd2,   0, 32'h0,          0, 0, 8'd0, 32'h0,        1, 0, 0, 0);
      add(0, 0, 0, 9'd2,   0, 32'h0,          1, 0, 8'd0, 32'h0,        0, 0, 0, 0);
      add(0, 0, 0, 9'd2,   1, 32'h3000_0000,  1, 1, 8'd0, 32'h3000_0000, 0, 0, 0, 0); // 28 from 0
      add(0, 0, 0, 9'd2,   1, 32'h3000_0001,  0, 1, 8'd1, 32'h3000_0001, 0, 0, 0, 0);
      add(0, 0, 0, 9'd2,   0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 1, 1, 0);
      add(0, 1, 1, 9'd2,   0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 0, 0, 0); // 31 stop wins
      add(0, 0, 1, 9'd2,   0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 0, 0, 0);
      add(0, 1, 0, 9'd257, 0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 0, 0, 1); // 33 bad len
      add(0, 0, 0, 9'd257, 0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 0, 0, 1);
      add(0, 1, 0, 9'd1,   0, 32'h0,          0, 0, 8'd0, 32'h0,        1, 0, 0, 0); // 35 clears err
      add(0, 0, 0, 9'd1,   0, 32'h0,          0, 0, 8'd0, 32'h0,        1, 0, 0, 0);
      add(0, 0, 0, 9'd1,   0, 32'h0,          1, 0, 8'd0, 32'h0,        0, 0, 0, 0);
      add(0, 1, 0, 9'd1,   0, 32'h0,          1, 0, 8'd0, 32'h0,        0, 0, 0, 0); // 38 start ignored
      add(0, 0, 0, 9'd1,   1, 32'h4000_0001,  0, 1, 8'd0, 32'h4000_0001, 0, 0, 0, 0);
      add(0, 0, 0, 9'd1,   0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 1, 1, 0);
      add(0, 0, 1, 9'd1,   0, 32'h0,          0, 0, 8'd0, 32'h0,        0, 0, 0, 0);

      foreach (tbl[i]) begin
         @(negedge clk_in);
         clr = tbl[i].clr; start = tbl[i].start; stop = tbl[i].stop;
         prog_len = tbl[i].len; src_valid = tbl[i].vld; src_data = tbl[i].d;
         @(posedge clk_in); #1;
         act = '{if0.src_ready, if0.prog_write, if0.prog_addr, if0.prog_data, cc0, run0, dn0, er0};
         exp = tbl[i].e;
         // address/data are only meaningful on a write or right after clr
         if (!(exp.wr || tbl[i].clr)) begin
            act.addr = '0; act.data = '0; exp.addr = '0; exp.data = '0;
         end
         check($sformatf("vec%0d", i), 64'(act), 64'(exp));
      end
      @(negedge clk_in);
      clr = 1'b0; start = 1'b0; stop = 1'b0; src_valid = 1'b0;

      run_load(1'b1, 8, 32'h2008_0000, 256);   // zero fill then 8 words
      run_load(1'b0, 256, 32'h5000_0000, 0);   // full depth, no wrap

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
